// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle between a multiply requester and seq_multiplier.
// The master issues operands and Start; the slave returns status and the product.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic                 Start;
    logic                 Signed_mode;
    logic [WIDTH-1:0]     Multiplicand_in;
    logic [WIDTH-1:0]     Multiplier_in;
    logic                 Busy;
    logic                 Ready;
    logic [2*WIDTH-1:0]   Product_out;
    logic                 Overflow;

    modport master (
        output Start, Signed_mode, Multiplicand_in, Multiplier_in,
        input  Busy, Ready, Product_out, Overflow
    );

    modport slave (
        input  Start, Signed_mode, Multiplicand_in, Multiplier_in,
        output Busy, Ready, Product_out, Overflow
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, fixed latency of WIDTH+2 cycles per product.
// Signed operands are multiplied as magnitudes and the sign is restored in FIX.
module seq_multiplier #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            Reset,
    seq_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     iter_count;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     mult_shift;
    logic                 signed_reg;
    logic                 neg_reg;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 overflow_reg;

    logic                 start_ok;
    logic                 signed_eff;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     in_mag_a;
    logic [WIDTH-1:0]     in_mag_b;
    logic                 iter_done;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   raw_prod;
    logic [2*WIDTH-1:0]   fixed_prod;
    logic                 fixed_ovf;

    // Operand conditioning and the single add/shift stage, all combinational
    always_comb begin
        signed_eff = SIGNED_EN && bus.Signed_mode;
        sign_a     = signed_eff && bus.Multiplicand_in[WIDTH-1];
        sign_b     = signed_eff && bus.Multiplier_in[WIDTH-1];
        in_mag_a   = sign_a ? (~bus.Multiplicand_in + 1'b1) : bus.Multiplicand_in;
        in_mag_b   = sign_b ? (~bus.Multiplier_in + 1'b1) : bus.Multiplier_in;
        start_ok   = bus.Start && ((state == IDLE) || (state == DONE));
        iter_done  = (iter_count == CNT_W'(WIDTH));
        add_sum    = {1'b0, acc_hi} + (mult_shift[0] ? {1'b0, mag_a} : '0);
        raw_prod   = {acc_hi, mult_shift};
        fixed_prod = neg_reg ? (~raw_prod + 1'b1) : raw_prod;
        if (signed_reg) begin
            fixed_ovf = !((&fixed_prod[2*WIDTH-1:WIDTH-1]) || !(|fixed_prod[2*WIDTH-1:WIDTH-1]));
        end else begin
            fixed_ovf = |fixed_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.Start) state_next = CALC;
            CALC: if (iter_done) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = bus.Start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The adder carry lands in the top product bit as the partial sum shifts right
    always_ff @(posedge clk) begin
        if (Reset) begin
            iter_count   <= '0;
            mag_a        <= '0;
            acc_hi       <= '0;
            mult_shift   <= '0;
            signed_reg   <= 1'b0;
            neg_reg      <= 1'b0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (start_ok) begin
                mag_a      <= in_mag_a;
                mult_shift <= in_mag_b;
                acc_hi     <= '0;
                iter_count <= '0;
                signed_reg <= signed_eff;
                neg_reg    <= sign_a ^ sign_b;
            end else if ((state == CALC) && !iter_done) begin
                acc_hi     <= add_sum[WIDTH:1];
                mult_shift <= {add_sum[0], mult_shift[WIDTH-1:1]};
                iter_count <= iter_count + 1'b1;
            end
            if (state == FIX) begin
                product_reg  <= fixed_prod;
                overflow_reg <= fixed_ovf;
            end
        end
    end

    assign bus.Busy        = (state == CALC) || (state == FIX);
    assign bus.Ready       = (state == DONE);
    assign bus.Product_out = product_reg;
    assign bus.Overflow    = overflow_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=8: stimulus pushes expected
// results, a negedge monitor pops and compares whenever Ready is high.
module tb_seq_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic Reset;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] product;
        logic        ovf;
    } exp_t;

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        bit          o;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one Start cycle from posedge+1 and returns 1 time unit after the capture edge
    task automatic applyStimulus(input bit sm, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] ep, input bit eo, input bit expect_result);
        if (expect_result) exp_q.push_back('{product: ep, ovf: eo});
        bus.Start           = 1'b1;
        bus.Signed_mode     = sm;
        bus.Multiplicand_in = a;
        bus.Multiplier_in   = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Waits for Ready, checks its latency and that Busy stayed high until then
    task automatic waitResult(input string tag, input int disturb);
        int  latency;
        bit  busy_ok;
        latency = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 2*W + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == disturb + 1) bus.Start = 1'b0;
            if (bus.Ready) begin
                latency = k;
                break;
            end
            if (!bus.Busy) busy_ok = 1'b0;
            if (k == disturb) begin
                bus.Start           = 1'b1;
                bus.Signed_mode     = 1'b1;
                bus.Multiplicand_in = 8'hFF;
                bus.Multiplier_in   = 8'h55;
            end
        end
        checkOutput({tag, "_ready_latency"}, 64'(latency), 64'(W + 2));
        checkOutput({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!Reset && bus.Ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("product", 64'(bus.Product_out), 64'(mon_exp.product));
                checkOutput("overflow", 64'(bus.Overflow), 64'(mon_exp.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'h008F, 1'b0};
        vecs[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 1'b0};
        vecs[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 1'b1};
        vecs[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b1};
        vecs[4]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0};
        vecs[5]  = '{1'b0, 8'h00,  8'hAB,  16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01, 1'b1};
        vecs[7]  = '{1'b1, 8'h80,  8'h01,  16'hFF80, 1'b0};
        vecs[8]  = '{1'b1, 8'h80,  8'hFF,  16'h0080, 1'b1};
        vecs[9]  = '{1'b0, 8'h10,  8'h10,  16'h0100, 1'b1};
        vecs[10] = '{1'b1, 8'h00,  8'h80,  16'h0000, 1'b0};

        // Reset together with Start must not capture anything
        Reset               = 1'b1;
        bus.Start           = 1'b1;
        bus.Signed_mode     = 1'b0;
        bus.Multiplicand_in = 8'd3;
        bus.Multiplier_in   = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(bus.Busy), 64'd0);
        checkOutput("reset_ready", 64'(bus.Ready), 64'd0);
        checkOutput("reset_product", 64'(bus.Product_out), 64'd0);
        checkOutput("reset_overflow", 64'(bus.Overflow), 64'd0);
        bus.Start = 1'b0;
        Reset     = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, 1'b1);
            waitResult($sformatf("vec%0d", i), 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_ready_pulse", i), 64'(bus.Ready), 64'd0);
        end

        $display("[TB] Start pulsed during CALC");
        applyStimulus(1'b0, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b1);
        waitResult("ignore_start", 3);
        @(posedge clk);
        #1;
        checkOutput("ignore_start_idle", 64'(bus.Busy), 64'd0);

        $display("[TB] Reset at iteration 4");
        applyStimulus(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_busy", 64'(bus.Busy), 64'd0);
        checkOutput("midreset_ready", 64'(bus.Ready), 64'd0);
        checkOutput("midreset_product", 64'(bus.Product_out), 64'd0);
        checkOutput("midreset_overflow", 64'(bus.Overflow), 64'd0);
        Reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b1);
        waitResult("after_reset", 0);
        @(posedge clk);
        #1;

        $display("[TB] Back-to-back Start in DONE");
        applyStimulus(1'b0, 8'h0C, 8'h0C, 16'h0090, 1'b0, 1'b1);
        waitResult("b2b_first", 0);
        applyStimulus(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1, 1'b1);
        checkOutput("b2b_busy_reasserted", 64'(bus.Busy), 64'd1);
        checkOutput("b2b_product_held", 64'(bus.Product_out), 64'h0090);
        waitResult("b2b_second", 0);
        @(posedge clk);
        #1;
        checkOutput("b2b_ready_pulse", 64'(bus.Ready), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 Parameter SIGNED_EN, default 1; 1 = Signed_mode honoured, 0 = Signed_mode ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Start  input  1  request to multiply; sampled only in IDLE or DONE.
REQ-006 Signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with Start.
REQ-007 Multiplicand_in  input  WIDTH  first operand; captured with Start.
REQ-008 Multiplier_in  input  WIDTH  second operand; captured with Start.
REQ-009 Busy  output  1  high while an operation is in progress.
REQ-010 Ready  output  1  one-cycle pulse marking a valid Product_out.
REQ-011 Product_out  output  2*WIDTH  full-precision product; held stable until the next accepted Start.
REQ-012 Overflow  output  1  product not representable in WIDTH bits in the captured mode; valid with Ready, held alongside Product_out.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE.
REQ-014 Transitions: IDLE -Start-> CALC; CALC -(WIDTH iterations)-> FIX; FIX -> DONE; DONE -Start-> CALC, DONE -!Start-> IDLE.
REQ-015 Capture edge (Start=1 in IDLE/DONE): latch operands and mode; latch magnitudes |A|, |B| when signed; latch result sign = signA XOR signB; clear the internal accumulator and iteration counter.
REQ-016 CALC: one shift-add iteration per cycle on magnitudes, add-then-shift-right with the adder carry kept as bit 2*WIDTH-1. Carry is never discarded and never drives outputs to X or Z.
REQ-017 Iteration counter width is clog2(WIDTH+1); CALC exits after exactly WIDTH iterations.
REQ-018 FIX: negate the 2*WIDTH result (two's complement) if signed mode and result sign = 1; otherwise pass it through. Load Product_out and Overflow.
REQ-019 Latency fixed and data-independent: capture at edge t; Ready=1 after edge t+WIDTH+2 for exactly one cycle. No zero-operand early exit.
REQ-020 Busy=1 from edge t through edge t+WIDTH+2, i.e. in CALC and FIX; Busy=0 in IDLE and DONE.
REQ-021 Start while Busy=1 is ignored; operands and mode are not re-sampled.
REQ-022 Start in the DONE cycle is accepted (back-to-back). Ready still pulses that cycle with the previous result, and Product_out keeps the previous value until the new FIX.
REQ-023 Unsigned Overflow = |Product[2W-1:W].
REQ-024 Signed Overflow = 1 unless bits [2W-1:W-1] are all equal.
REQ-025 Most-negative operand (-2^(W-1)) handled correctly; its magnitude is held in W bits unsigned.
REQ-026 Product_out and Overflow change only in FIX or on Reset.

Reset
REQ-027 Reset=1 at a rising edge forces IDLE, Busy=0, Ready=0, Overflow=0, Product_out=0, and clears the counter and accumulator, in any state including mid-CALC.
REQ-028 Reset has priority over Start in the same cycle; Start is not captured.
REQ-029 After Reset deasserts, the first Start is accepted normally.

Verification (WIDTH=8)
REQ-030 Unsigned 13 x 11 -> Product_out=0x008F, Overflow=0, Ready exactly 10 cycles after the capture edge, single-cycle pulse.
REQ-031 Signed -3 (0xFD) x 5 -> 0xFFF1, Overflow=0. Signed 0x80 x 0x80 -> 0x4000, Overflow=1.
REQ-032 Unsigned 0xFF x 0xFF -> 0xFE01, Overflow=1. Same operands signed -> 0x0001, Overflow=0.
REQ-033 Start pulsed with new operands during CALC -> ignored; result matches the first operands; Busy continuously high.
REQ-034 Reset asserted at iteration 4 -> next edge Busy=0, Product_out=0, Overflow=0, no Ready. New Start then yields the correct product.
REQ-035 Start held high across DONE with new operands -> Ready pulses with the old result, Busy reasserts the same cycle, second result 10 cycles later.
